div_rr_arbiter: RTL and testbench
=================================

// Module: div_rr_arbiter
// PURPOSE
//  Shares one 10-bit fixed-point divider (div_top) among NUM_REQ requesters.
//  Round-robin arbitration; latches the winner's operands and drives the divider start pulse.
//  Waits for completion and returns quotient plus ovf/dvz flags to the winner only, with a done pulse.
//  Sits between client FSMs and the single divider instance; the divider datapath is unchanged.
// PARAMETERS
//  NUM_REQ    4    number of requesters (2..8)
//  W          10   operand/quotient width; must match divider
//  TIMEOUT    63   max cycles in RUN before abort with err (6-bit counter)
// PORTS
//  clk        in   1          rising-edge clock
//  rst        in   1          asynchronous reset, ACTIVE-LOW
//  req        in   NUM_REQ    level request; held until done for that index
//  a_in       in   NUM_REQ*W  dividends, slot i = [i*W +: W]
//  b_in       in   NUM_REQ*W  divisors, same packing
//  gnt        out  NUM_REQ    one-hot, high from grant until done cycle inclusive
//  done       out  NUM_REQ    one-hot, 1-cycle completion pulse
//  q_out      out  W          quotient, valid in done cycle, held until next done
//  ovf_out    out  1          divider ovf, qualified by done
//  dvz_out    out  1          divider dvz, qualified by done
//  err_out    out  1          timeout abort, qualified by done
//  div_start  out  1          1-cycle start pulse to divider
//  div_a      out  W          latched dividend to divider
//  div_b      out  W          latched divisor to divider
//  div_busy   in   1          divider busy
//  div_valid  in   1          divider result valid
//  div_ovf    in   1          divider overflow
//  div_dvz    in   1          divider divide-by-zero
//  div_q      in   W          divider quotient
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, all outputs 0, rr pointer = 0, timeout cnt 0.
//  FSM: IDLE -> ISSUE -> RUN -> RESP -> IDLE.
//   IDLE: if |req, pick first set bit searching from ptr upward with wrap; latch idx,
//         a_in/b_in slot into div_a/div_b; assert gnt[idx]; go ISSUE.
//   ISSUE: div_start=1 for exactly one cycle; clear timeout cnt; go RUN.
//   RUN: completion = div_valid | div_dvz | div_ovf; on completion capture div_q and
//        flags, go RESP. cnt increments each RUN cycle; cnt==TIMEOUT -> err=1, q=0, go RESP.
//   RESP: done[idx]=1 one cycle, gnt[idx] drops after; ptr <= idx+1 (wraps to 0). go IDLE.
//  Latency req->done: 3 cycles + divider compute time. Min gap between grants: 1 IDLE cycle.
//  Operands latched at grant; requester changes to a_in/b_in after grant are ignored.
//  Request dropped while granted: transaction still completes; done still pulses.
//  Simultaneous reqs: strict rotation; a requester waits at most NUM_REQ-1 transactions.
//  Completion and timeout in same cycle: completion wins, err=0.
//  dvz/ovf reported as-is; q_out carries div_q in that cycle (don't-care to clients).
//  Reset mid-operation: FSM/outputs clear at once; divider is reset by its own path.
//  div_a/div_b stay stable from grant through RESP.
// STRUCTURE
//  Shared package div_pkg: W, state encoding (IDLE/ISSUE/RUN/RESP), TIMEOUT width.
//  One sub-module: rr_pick (comb: req, ptr -> one-hot grant, idx, any).
//  Top holds FSM, operand/result registers, timeout counter, rr pointer.
// TESTING
//  Single req[0], A=10'h080 B=10'h040 -> div_start 1 pulse, done[0], q_out = divider q, flags 0.
//  req=4'b1111 from reset -> grants in order 0,1,2,3, each done one-hot, no overlap.
//  ptr=2 after serving 1, req=4'b0011 -> grant 0 next (wrap), then 1.
//  B=0 on req[2] -> done[2] with dvz_out=1, err_out=0; next grant proceeds normally.
//  Stub divider never completes -> done after TIMEOUT RUN cycles, err_out=1, q_out=0.
//  rst low during RUN -> gnt/done/div_start 0 same cycle; after release req re-granted.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and FSM encoding for the divider round-robin arbiter.
package div_pkg;
   localparam int NUM_REQ_DEF = 4;
   localparam int W_DEF       = 10;
   localparam int TIMEOUT_DEF = 63;
   localparam int CNT_W       = 6;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RUN   = 2'd2,
      ST_RESP  = 2'd3
   } state_e;
endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping to bit 0.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);
   logic [N-1:0] mask;
   logic [N-1:0] masked;
   logic [N-1:0] src;

   for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign mask[gi] = (IW'(gi) >= ptr_i);
   end

   // Requests at/after ptr take priority; otherwise wrap to the lowest one.
   assign masked = req_i & mask;
   assign src    = (|masked) ? masked : req_i;
   assign gnt_o  = src & (~src + 1'b1);
   assign any_o  = |req_i;

   for (genvar bi = 0; bi < IW; bi++) begin : g_enc
      logic [N-1:0] sel;
      for (genvar gi = 0; gi < N; gi++) begin : g_bit
         assign sel[gi] = gnt_o[gi] & (((gi >> bi) & 1) == 1);
      end
      assign idx_o[bi] = |sel;
   end
endmodule

// File: rtl/div_rr_arbiter.sv
// Shares one fixed-point divider among NUM_REQ clients with round-robin
// arbitration, operand latching, start pulse and per-client done/result.
module div_rr_arbiter
   import div_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int W       = W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NUM_REQ-1:0]   req_i,
   input  logic [NUM_REQ*W-1:0] a_i,
   input  logic [NUM_REQ*W-1:0] b_i,
   output logic [NUM_REQ-1:0]   gnt_o,
   output logic [NUM_REQ-1:0]   done_o,
   output logic [W-1:0]         q_o,
   output logic                 ovf_o,
   output logic                 dvz_o,
   output logic                 err_o,
   output logic                 div_start_o,
   output logic [W-1:0]         div_a_o,
   output logic [W-1:0]         div_b_o,
   input  logic                 div_busy_i,
   input  logic                 div_valid_i,
   input  logic                 div_ovf_i,
   input  logic                 div_dvz_i,
   input  logic [W-1:0]         div_q_i
);
   localparam int IW = $clog2(NUM_REQ);

   state_e             state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d, ptr_q, ptr_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [W-1:0]       a_q, a_d, b_q, b_d, q_q, q_d;
   logic               ovf_q, ovf_d, dvz_q, dvz_d, err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;
   logic [W-1:0]       a_slot [2**IW];
   logic [W-1:0]       b_slot [2**IW];

   // Completion flags are authoritative; busy carries no extra information here.
   logic unused_busy;
   assign unused_busy = div_busy_i;

   for (genvar gi = 0; gi < 2**IW; gi++) begin : g_slot
      if (gi < NUM_REQ) begin : g_used
         assign a_slot[gi] = a_i[gi*W +: W];
         assign b_slot[gi] = b_i[gi*W +: W];
      end else begin : g_pad
         assign a_slot[gi] = '0;
         assign b_slot[gi] = '0;
      end
   end

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req_i (req_i),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         q_q     <= '0;
         ovf_q   <= 1'b0;
         dvz_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         q_q     <= q_d;
         ovf_q   <= ovf_d;
         dvz_q   <= dvz_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      a_d     = a_q;
      b_d     = b_q;
      q_d     = q_q;
      ovf_d   = ovf_q;
      dvz_d   = dvz_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               idx_d   = pick_idx;
               gnt_d   = pick_gnt;
               a_d     = a_slot[pick_idx];
               b_d     = b_slot[pick_idx];
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            // A completion arriving in the last allowed cycle still beats the abort.
            if (div_valid_i || div_dvz_i || div_ovf_i) begin
               q_d     = div_q_i;
               ovf_d   = div_ovf_i;
               dvz_d   = div_dvz_i;
               err_d   = 1'b0;
               state_d = ST_RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               q_d     = '0;
               ovf_d   = 1'b0;
               dvz_d   = 1'b0;
               err_d   = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            gnt_d   = '0;
            ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign gnt_o       = gnt_q;
   assign done_o      = (state_q == ST_RESP) ? gnt_q : '0;
   assign q_o         = q_q;
   assign ovf_o       = ovf_q & (state_q == ST_RESP);
   assign dvz_o       = dvz_q & (state_q == ST_RESP);
   assign err_o       = err_q & (state_q == ST_RESP);
   assign div_start_o = (state_q == ST_ISSUE);
   assign div_a_o     = a_q;
   assign div_b_o     = b_q;
endmodule

// File: tb/tb_div_rr_arbiter.sv
// Directed bench for div_rr_arbiter with a latency-programmable stub divider.
module tb_div_rr_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [39:0] a_in, b_in;
   logic [3:0]  gnt, done;
   logic [9:0]  q_out, div_a, div_b, div_q;
   logic        ovf_out, dvz_out, err_out, div_start;
   logic        div_busy, div_valid, div_ovf, div_dvz;

   int checks = 0;
   int errors = 0;

   int   stub_lat  = 0;
   bit   stub_hang = 0;
   bit   stub_ovf  = 0;
   logic s_run;
   int   s_cnt;
   logic [9:0] s_a, s_b;

   localparam logic [39:0] A_OPS  = {10'h3FF, 10'h0C0, 10'h100, 10'h080};
   localparam logic [39:0] B_OPS  = {10'h010, 10'h030, 10'h020, 10'h040};
   localparam logic [39:0] B_ZERO = {10'h010, 10'h000, 10'h020, 10'h040};

   typedef struct {
      logic [3:0]  req;
      logic [39:0] a;
      logic [39:0] b;
      int          lat;
      bit          hang;
      bit          ovf;
      int          idx;
      logic [9:0]  q;
      bit          dvz;
      bit          eovf;
      bit          err;
      int          cyc;
   } vec_t;

   vec_t vecs[15];

   always #5 clk = ~clk;

   div_rr_arbiter dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_i       (req),
      .a_i         (a_in),
      .b_i         (b_in),
      .gnt_o       (gnt),
      .done_o      (done),
      .q_o         (q_out),
      .ovf_o       (ovf_out),
      .dvz_o       (dvz_out),
      .err_o       (err_out),
      .div_start_o (div_start),
      .div_a_o     (div_a),
      .div_b_o     (div_b),
      .div_busy_i  (div_busy),
      .div_valid_i (div_valid),
      .div_ovf_i   (div_ovf),
      .div_dvz_i   (div_dvz),
      .div_q_i     (div_q)
   );

   // Stub divider: result appears lat+1 cycles after the start pulse.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_run <= 1'b0; s_cnt <= 0; s_a <= '0; s_b <= '0;
         div_valid <= 1'b0; div_dvz <= 1'b0; div_ovf <= 1'b0; div_q <= '0;
      end else begin
         div_valid <= 1'b0; div_dvz <= 1'b0; div_ovf <= 1'b0;
         if (div_start) begin
            s_run <= 1'b1; s_cnt <= stub_lat; s_a <= div_a; s_b <= div_b;
         end else if (s_run && !stub_hang) begin
            if (s_cnt == 0) begin
               s_run <= 1'b0;
               div_q <= (s_b == 10'd0) ? 10'h3FF : s_a / s_b;
               if (stub_ovf) div_ovf <= 1'b1;
               else if (s_b == 10'd0) div_dvz <= 1'b1;
               else div_valid <= 1'b1;
            end else begin
               s_cnt <= s_cnt - 1;
            end
         end
      end
   end
   assign div_busy = s_run;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int n, input vec_t v);
      int         starts;
      int         cyc;
      bit         seen;
      logic [3:0] oh;
      starts = 0; cyc = 0; seen = 0;
      oh = 4'b0001 << v.idx;
      @(posedge clk); #1;
      chk("idle_gap_gnt", 32'(gnt), 32'd0);
      req = v.req; a_in = v.a; b_in = v.b;
      stub_lat = v.lat; stub_hang = v.hang; stub_ovf = v.ovf;
      while (!seen && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (div_start) starts++;
         if (done != 4'b0) seen = 1;
      end
      if (!seen) begin
         chk("done_seen", 32'd0, 32'd1);
         return;
      end
      chk("done_onehot", 32'(done), 32'(oh));
      chk("gnt_at_done", 32'(gnt), 32'(oh));
      chk("q_out", 32'(q_out), 32'(v.q));
      chk("dvz_out", 32'(dvz_out), 32'(v.dvz));
      chk("ovf_out", 32'(ovf_out), 32'(v.eovf));
      chk("err_out", 32'(err_out), 32'(v.err));
      chk("start_pulses", 32'(starts), 32'd1);
      chk("latency", 32'(cyc), 32'(v.cyc));
      chk("div_a_held", 32'(div_a), 32'(v.a[v.idx*10 +: 10]));
      $display("txn %0d: req=%b done=%b q=%03h dvz=%0b ovf=%0b err=%0b cycles=%0d",
               n, v.req, done, q_out, dvz_out, ovf_out, err_out, cyc);
   endtask

   task automatic wait_gnt(input string name, output bit ok);
      ok = 0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(posedge clk); #1;
         if (gnt != 4'b0) ok = 1;
      end
      if (!ok) chk(name, 32'd0, 32'd1);
   endtask

   task automatic wait_done(input string name, output bit ok);
      ok = 0;
      for (int c = 0; c < 200 && !ok; c++) begin
         @(posedge clk); #1;
         if (done != 4'b0) ok = 1;
      end
      if (!ok) chk(name, 32'd0, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      bit ok;
      //          req      a      b       lat hng ovf idx q       dvz eovf err cyc
      vecs[0]  = '{4'b1111, A_OPS, B_OPS,  0,  0,  0,  0, 10'h002, 0,  0,  0,  4};
      vecs[1]  = '{4'b1110, A_OPS, B_OPS,  2,  0,  0,  1, 10'h008, 0,  0,  0,  6};
      vecs[2]  = '{4'b1100, A_OPS, B_OPS,  1,  0,  0,  2, 10'h004, 0,  0,  0,  5};
      vecs[3]  = '{4'b1000, A_OPS, B_OPS,  0,  0,  0,  3, 10'h03F, 0,  0,  0,  4};
      vecs[4]  = '{4'b0011, A_OPS, B_OPS,  0,  0,  0,  0, 10'h002, 0,  0,  0,  4};
      vecs[5]  = '{4'b0010, A_OPS, B_OPS,  0,  0,  0,  1, 10'h008, 0,  0,  0,  4};
      vecs[6]  = '{4'b0011, A_OPS, B_OPS,  0,  0,  0,  0, 10'h002, 0,  0,  0,  4};
      vecs[7]  = '{4'b0010, A_OPS, B_OPS,  0,  0,  0,  1, 10'h008, 0,  0,  0,  4};
      vecs[8]  = '{4'b0100, A_OPS, B_ZERO, 1,  0,  0,  2, 10'h3FF, 1,  0,  0,  5};
      vecs[9]  = '{4'b0001, A_OPS, B_OPS,  0,  0,  0,  0, 10'h002, 0,  0,  0,  4};
      vecs[10] = '{4'b1000, A_OPS, B_OPS,  0,  0,  1,  3, 10'h03F, 0,  1,  0,  4};
      vecs[11] = '{4'b0010, A_OPS, B_OPS, 61,  0,  0,  1, 10'h008, 0,  0,  0, 65};
      vecs[12] = '{4'b0100, A_OPS, B_OPS,  0,  1,  0,  2, 10'h000, 0,  0,  1, 65};
      vecs[13] = '{4'b0100, A_OPS, B_OPS, 62,  0,  0,  2, 10'h000, 0,  0,  1, 65};
      vecs[14] = '{4'b0001, A_OPS, B_OPS,  0,  0,  0,  0, 10'h002, 0,  0,  0,  4};

      rst_n = 1'b0; req = '0; a_in = '0; b_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_start", 32'(div_start), 32'd0);
      chk("rst_q", 32'(q_out), 32'd0);
      chk("rst_err", 32'(err_out), 32'd0);
      chk("rst_div_a", 32'(div_a), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

      // Operands changed and request dropped after grant: transaction unaffected.
      @(posedge clk); #1;
      a_in = A_OPS; b_in = B_OPS; stub_lat = 0; stub_hang = 0; stub_ovf = 0;
      req = 4'b0001;
      wait_gnt("late_change_gnt_seen", ok);
      if (ok) begin
         chk("late_change_gnt", 32'(gnt), 32'd1);
         a_in = {A_OPS[39:10], 10'h3FF};
         b_in = {B_OPS[39:10], 10'h001};
         req  = 4'b0000;
         wait_done("late_change_done_seen", ok);
         if (ok) begin
            chk("late_change_done", 32'(done), 32'd1);
            chk("late_change_q", 32'(q_out), 32'h002);
            chk("late_change_div_a", 32'(div_a), 32'h080);
            chk("late_change_div_b", 32'(div_b), 32'h040);
            $display("txn late_change: done=%b q=%03h", done, q_out);
         end
      end

      // Reset during RUN clears outputs at once; held request is re-granted.
      @(posedge clk); #1;
      a_in = A_OPS; b_in = B_OPS; stub_hang = 1; req = 4'b0100;
      wait_gnt("rst_run_gnt_seen", ok);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_run_gnt", 32'(gnt), 32'd0);
      chk("rst_run_done", 32'(done), 32'd0);
      chk("rst_run_start", 32'(div_start), 32'd0);
      chk("rst_run_div_a", 32'(div_a), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; stub_hang = 0; stub_lat = 0;
      wait_gnt("rst_regrant_seen", ok);
      if (ok) begin
         chk("rst_regrant_gnt", 32'(gnt), 32'b0100);
         wait_done("rst_regrant_done_seen", ok);
         if (ok) begin
            chk("rst_regrant_done", 32'(done), 32'b0100);
            chk("rst_regrant_q", 32'(q_out), 32'h004);
            chk("rst_regrant_err", 32'(err_out), 32'd0);
            $display("txn rst_regrant: done=%b q=%03h", done, q_out);
         end
      end
      req = '0;
      repeat (2) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
